// File: rtl/jtkcpu_stack_ctrl.sv
// Sequencer for 6809-style PSHS/PSHU/PULS/PULU transfers: walks the register mask one byte
// at a time and produces the stack-pointer and memory strobes for the bus unit.
module jtkcpu_stack_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cen,
    input  logic       start,
    input  logic       pull,
    input  logic       us_sel,
    input  logic [7:0] mask,
    output logic [7:0] psh_sel,
    output logic       psh_hihalf,
    output logic       psh_ussel,
    output logic       psh_dec,
    output logic       pul_en,
    output logic       stack_busy,
    output logic       mem_we,
    output logic       mem_re,
    output logic       done,
    output logic [3:0] byte_cnt
);

    typedef enum logic [2:0] {StIdle, StDec, StWr, StRd, StFin} state_e;

    state_e     state_q, state_d;
    logic [7:0] sel_q, sel_d;
    logic       hihalf_q, hihalf_d;
    logic       ussel_q, ussel_d;
    logic       pull_q, pull_d;
    logic [3:0] cnt_q, cnt_d;

    logic [2:0] hi_idx, lo_idx, cur_idx;
    logic       cur_wide, byte_last;

    // Push services the highest pending bit, pull the lowest.
    always_comb begin
        hi_idx = 3'd0;
        lo_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (sel_q[i]) hi_idx = 3'(i);
        end
        for (int i = 7; i >= 0; i--) begin
            if (sel_q[i]) lo_idx = 3'(i);
        end
    end

    assign cur_idx  = pull_q ? lo_idx : hi_idx;
    assign cur_wide = cur_idx[2];
    // Push ends a 16-bit register on its high byte, pull ends it on its low byte.
    assign byte_last = !cur_wide || (hihalf_q != pull_q);

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        hihalf_d = hihalf_q;
        ussel_d  = ussel_q;
        pull_d   = pull_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    pull_d   = pull;
                    ussel_d  = us_sel;
                    sel_d    = mask;
                    hihalf_d = pull;
                    cnt_d    = 4'd0;
                    if (mask == 8'h00) state_d = StFin;
                    else if (pull)     state_d = StRd;
                    else               state_d = StDec;
                end
            end
            StDec: state_d = StWr;
            StWr, StRd: begin
                cnt_d = cnt_q + 4'd1;
                if (byte_last) begin
                    sel_d    = sel_q & ~(8'd1 << cur_idx);
                    hihalf_d = pull_q;
                end else begin
                    hihalf_d = ~hihalf_q;
                end
                if (sel_d == 8'h00)       state_d = StFin;
                else if (state_q == StWr) state_d = StDec;
                else                      state_d = StRd;
            end
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            sel_q    <= 8'h00;
            hihalf_q <= 1'b0;
            ussel_q  <= 1'b0;
            pull_q   <= 1'b0;
            cnt_q    <= 4'd0;
        end else if (cen) begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            hihalf_q <= hihalf_d;
            ussel_q  <= ussel_d;
            pull_q   <= pull_d;
            cnt_q    <= cnt_d;
        end
    end

    assign psh_sel    = sel_q;
    assign psh_hihalf = hihalf_q & cur_wide;
    assign psh_ussel  = ussel_q;
    assign psh_dec    = (state_q == StDec);
    assign pul_en     = (state_q == StRd);
    assign stack_busy = (state_q != StIdle);
    assign mem_we     = (state_q == StWr);
    assign mem_re     = (state_q == StRd);
    assign done       = (state_q == StFin);
    assign byte_cnt   = cnt_q;

endmodule

// File: tb/tb_jtkcpu_stack_ctrl.sv
// Bench for jtkcpu_stack_ctrl: byte-list model compared every cycle, plus directed
// literal checks on latency, byte counts, reset and start filtering.
module tb_jtkcpu_stack_ctrl;

    logic       clk = 1'b0;
    logic       rst_n, cen, start, pull, us_sel;
    logic [7:0] mask;
    logic [7:0] psh_sel;
    logic       psh_hihalf, psh_ussel, psh_dec, pul_en, stack_busy, mem_we, mem_re, done;
    logic [3:0] byte_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    jtkcpu_stack_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cen        (cen),
        .start      (start),
        .pull       (pull),
        .us_sel     (us_sel),
        .mask       (mask),
        .psh_sel    (psh_sel),
        .psh_hihalf (psh_hihalf),
        .psh_ussel  (psh_ussel),
        .psh_dec    (psh_dec),
        .pul_en     (pul_en),
        .stack_busy (stack_busy),
        .mem_we     (mem_we),
        .mem_re     (mem_re),
        .done       (done),
        .byte_cnt   (byte_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] sel;
        logic       hi, us, dec, pul, busy, we, re, done;
        logic [3:0] cnt;
    } exp_t;

    exp_t dut_v;
    assign dut_v = {psh_sel, psh_hihalf, psh_ussel, psh_dec, pul_en, stack_busy,
                    mem_we, mem_re, done, byte_cnt};

    exp_t cur = '0;
    exp_t pend[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expand a request into the per-cycle output records it must produce.
    function automatic void build(input logic [7:0] m, input logic p, input logic u);
        logic [7:0] r;
        int         k, i, nb;
        exp_t       e;
        r = m;
        k = 0;
        pend.delete();
        for (int j = 0; j < 8; j++) begin
            i = p ? j : 7 - j;
            if (m[i]) begin
                nb = (i >= 4) ? 2 : 1;
                for (int b = 0; b < nb; b++) begin
                    e      = '0;
                    e.sel  = r;
                    e.hi   = (nb == 2) ? (p ? (b == 0) : (b == 1)) : 1'b0;
                    e.us   = u;
                    e.busy = 1'b1;
                    e.cnt  = 4'(k);
                    if (p) begin
                        e.re  = 1'b1;
                        e.pul = 1'b1;
                        pend.push_back(e);
                    end else begin
                        e.dec = 1'b1;
                        pend.push_back(e);
                        e.dec = 1'b0;
                        e.we  = 1'b1;
                        pend.push_back(e);
                    end
                    k++;
                end
                r[i] = 1'b0;
            end
        end
        e      = '0;
        e.us   = u;
        e.busy = 1'b1;
        e.done = 1'b1;
        e.cnt  = 4'(k);
        pend.push_back(e);
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                pend.delete();
                cur = '0;
            end else if (cen) begin
                if (pend.size() != 0) begin
                    cur = pend.pop_front();
                end else if (cur.busy) begin
                    cur.busy = 1'b0;
                    cur.done = 1'b0;
                end else if (start) begin
                    build(mask, pull, us_sel);
                    cur = pend.pop_front();
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            check("outputs_vs_model", 32'(dut_v), 32'(cur));
        end
    end

    task automatic run_op(input logic [7:0] m, input logic p, input logic u, input bit tog,
                          input int exp_edges, input int exp_cnt, input string name);
        int   edges;
        bit   seen;
        logic c;
        @(negedge clk);
        mask = m; pull = p; us_sel = u; start = 1'b1; cen = 1'b1;
        edges = 0; seen = 1'b0; c = 1'b1;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(posedge clk);
            if (cen) edges++;
            @(negedge clk);
            start = 1'b0;
            if (done) seen = 1'b1;
            else begin
                if (tog) c = ~c;
                cen = c;
            end
        end
        check({name, "_done_seen"}, 32'(seen), 32'd1);
        check({name, "_done_edge"}, 32'(edges), 32'(exp_edges));
        check({name, "_byte_cnt"}, 32'(byte_cnt), 32'(exp_cnt));
        cen = 1'b1;
        @(negedge clk);
        check({name, "_idle_busy"}, 32'(stack_busy), 32'd0);
        check({name, "_idle_cnt"}, 32'(byte_cnt), 32'(exp_cnt));
    endtask

    initial begin
        int wr_seen;
        rst_n = 1'b0; cen = 1'b0; start = 1'b0; pull = 1'b0; us_sel = 1'b0; mask = 8'h00;
        repeat (2) @(negedge clk);
        check("reset_outputs", 32'(dut_v), 32'd0);
        rst_n = 1'b1;
        cen   = 1'b1;
        repeat (2) @(negedge clk);
        check("post_reset_quiet", 32'(dut_v), 32'd0);

        run_op(8'h06, 1'b0, 1'b0, 1'b0, 5, 2, "push06");
        run_op(8'h80, 1'b0, 1'b0, 1'b0, 5, 2, "push80");
        run_op(8'hFF, 1'b1, 1'b1, 1'b0, 13, 12, "pullFF");
        check("pullFF_ussel", 32'(psh_ussel), 32'd1);
        run_op(8'h00, 1'b0, 1'b0, 1'b0, 1, 0, "push00");
        run_op(8'h30, 1'b0, 1'b0, 1'b1, 9, 4, "push30_cen");

        // Reset during the second write of a full push.
        @(negedge clk);
        mask = 8'hFF; pull = 1'b0; us_sel = 1'b0; start = 1'b1; cen = 1'b1;
        wr_seen = 0;
        for (int i = 0; i < 50 && wr_seen < 2; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (mem_we) wr_seen++;
        end
        check("rst_mid_second_wr", 32'(wr_seen), 32'd2);
        #1 rst_n = 1'b0;
        #1 check("rst_mid_async_clear", 32'(dut_v), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_mid_no_done", 32'(dut_v), 32'd0);
        run_op(8'h01, 1'b0, 1'b0, 1'b0, 3, 1, "push01");

        // Start coinciding with done must be dropped.
        @(negedge clk);
        mask = 8'h00; start = 1'b1;
        @(negedge clk);
        check("fin_done", 32'(done), 32'd1);
        mask = 8'h06;
        @(negedge clk);
        start = 1'b0;
        check("start_in_fin_ignored", 32'(stack_busy), 32'd0);
        check("start_in_fin_cnt", 32'(byte_cnt), 32'd0);
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/jtkcpu_stack_ctrl.md
JTKCPU_STACK_CTRL -- requirements
Module: jtkcpu_stack_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port cen, input, 1 bit: clock enable; state advances only on edges where cen=1.
REQ-004 SHALL have port start, input, 1 bit: a one-cycle request to begin a stack transfer.
REQ-005 SHALL have port pull, input, 1 bit: 0 selects push, 1 selects pull; sampled with start.
REQ-006 SHALL have port us_sel, input, 1 bit: 1 selects U as the stack pointer, 0 selects S; sampled with start.
REQ-007 SHALL have port mask, input, 8 bits: register set to transfer (bit7 PC, bit6 U/S, bit5 Y, bit4 X, bit3 DP, bit2 B, bit1 A, bit0 CC); sampled with start.
REQ-008 SHALL have port psh_sel, output, 8 bits: the remaining unserviced mask.
REQ-009 SHALL have port psh_hihalf, output, 1 bit: 1 when the current byte is the high half of a 16-bit register.
REQ-010 SHALL have port psh_ussel, output, 1 bit: the latched us_sel.
REQ-011 SHALL have port psh_dec, output, 1 bit: stack-pointer decrement strobe.
REQ-012 SHALL have port pul_en, output, 1 bit: high for the whole of a pull operation.
REQ-013 SHALL have port stack_busy, output, 1 bit: high while a transfer is in progress.
REQ-014 SHALL have port mem_we, output, 1 bit: write-byte strobe.
REQ-015 SHALL have port mem_re, output, 1 bit: read-byte strobe.
REQ-016 SHALL have port done, output, 1 bit: one-cen-cycle completion pulse.
REQ-017 SHALL have port byte_cnt, output, 4 bits: number of bytes transferred in the current or last operation.

Function
REQ-018 SHALL implement states IDLE, DEC, WR, RD and FIN.
REQ-019 IDLE: when start=1 and cen=1, SHALL latch pull, us_sel and mask, clear byte_cnt, and go to DEC if pushing, RD if pulling, or FIN if mask==0.
REQ-020 Push order SHALL be highest set bit first (PC to CC); 16-bit registers push the low byte first, then the high byte.
REQ-021 Each push byte SHALL take 2 cen cycles: DEC (psh_dec=1 with psh_sel!=0), then WR (mem_we=1).
REQ-022 After WR, byte_cnt SHALL increment; if the register is complete, its bit SHALL clear in psh_sel.
REQ-023 After WR, the next state SHALL be DEC if psh_sel is still nonzero, otherwise FIN.
REQ-024 Pull order SHALL be lowest set bit first (CC to PC); 16-bit registers pull the high byte first, then the low byte.
REQ-025 Each pull byte SHALL take 1 cen cycle in RD: mem_re=1, pul_en=1, psh_dec=0; bit clear and byte_cnt update SHALL follow the same rules as push.
REQ-026 psh_hihalf SHALL be 0 for the 8-bit registers (bits 3..0).
REQ-027 psh_hihalf SHALL toggle between the two bytes of a 16-bit register.
REQ-028 psh_hihalf SHALL start each 16-bit register at 0 on push and at 1 on pull.
REQ-029 FIN SHALL assert done=1 for one cen cycle, clear pul_en, and return to IDLE.
REQ-030 stack_busy SHALL be 1 in DEC, WR, RD and FIN, and 0 in IDLE.
REQ-031 start SHALL be ignored outside IDLE.
REQ-032 start asserted in the same cycle as done SHALL be ignored.
REQ-033 With cen=0, all outputs and state SHALL hold.
REQ-034 The strobes psh_dec, mem_we and mem_re SHALL be qualified by state only; the consumer gates them with cen.
REQ-035 byte_cnt SHALL saturate-free cover 0..12; its maximum value SHALL be 12 (the full mask).
REQ-036 byte_cnt SHALL hold its value in IDLE until the next accepted start.

Reset
REQ-037 rst_n=0 SHALL force IDLE and clear psh_sel, psh_hihalf, psh_ussel, psh_dec, pul_en, stack_busy, mem_we, mem_re, done and byte_cnt, all to 0, immediately and asynchronously.
REQ-038 Reset mid-operation SHALL abandon the transfer with no done pulse.
REQ-039 After rst_n rises, no strobe SHALL assert until a new start is accepted.

Verification
REQ-040 Push, mask=8'h06, pull=0, cen=1: DEC,WR,DEC,WR; the first WR shows psh_sel=8'h06, the second psh_sel=8'h02; done on cycle 5; byte_cnt=2.
REQ-041 Push, mask=8'h80: WR sequence has psh_hihalf 0 then 1; 4 strobe cycles; done; byte_cnt=2; psh_sel=8'h00.
REQ-042 Pull, mask=8'hFF, us_sel=1: 12 RD cycles; bit-clear order is bit0 first and bit7 last; each 16-bit register reads hihalf 1 then 0; pul_en=1 throughout; psh_ussel=1; done; byte_cnt=12.
REQ-043 start with mask=8'h00: FIN next cycle; done=1; no mem_we, mem_re or psh_dec; byte_cnt=0.
REQ-044 Push mask=8'h30 with cen toggling 1/0: the sequence advances only on cen=1 edges, and outputs stay stable across cen=0 edges.
REQ-045 Assert rst_n=0 during the second WR of mask=8'hFF: all outputs read 0 immediately; after release, a start with mask=8'h01 completes normally with byte_cnt=1.
